// File: rtl/tiny_rv_csr_file.sv
// Machine-mode CSR file for the tiny_rv execute stage: Zicsr decode, trap CSRs, counters.
// Define TINY_RV_CSR_COUNTERS_EN to build mcycle/minstret and their user-mode shadows.
module tiny_rv_csr_file #(
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [31:0] HART_ID       = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  src_idx,
  input  logic [31:0] rs1,
  input  logic [11:0] csr,
  input  logic        i_retire,
  input  logic        i_trap,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_cause,
  input  logic        i_mret,
  output logic        active,
  output logic        illegal,
  output logic [31:0] result,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  localparam logic [6:0]  OP_SYSTEM     = 7'b1110011;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;

  logic        implemented;
  logic [31:0] old_value;
  logic [31:0] new_value;
  logic [31:0] src;
  logic        wr_en;
  logic        read_only;
  logic        commit;
  csr_op_e     op;

  logic [63:0] cycle_full;
  logic [63:0] instret_full;

  // ---------------------------------------------------------------- decode
  assign op        = csr_op_e'(funct3[1:0]);
  assign active    = (opcode == OP_SYSTEM) && (op != OP_NONE);
  assign src       = funct3[2] ? {27'd0, src_idx} : rs1;
  // Set/clear forms with a zero source are pure reads and must not trip read-only checks.
  assign wr_en     = (op == OP_RW) || (src_idx != 5'd0);
  assign read_only = (csr[11:10] == 2'b11);
  assign illegal   = active && (!implemented || (wr_en && read_only));
  assign result    = (active && !illegal) ? old_value : 32'd0;
  assign commit    = i_valid && active && !illegal && wr_en && !i_trap && !i_mret;

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise unlisted addresses would hold their last value and infer a latch.
  always_comb begin
    implemented = 1'b1;
    old_value   = 32'd0;
    case (csr)
      CSR_MSTATUS:  old_value = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      CSR_MISA:     old_value = MISA_VALUE;
      CSR_MTVEC:    old_value = mtvec;
      CSR_MSCRATCH: old_value = mscratch;
      CSR_MEPC:     old_value = mepc;
      CSR_MCAUSE:   old_value = mcause;
      CSR_MHARTID:  old_value = HART_ID;
`ifdef TINY_RV_CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    old_value = cycle_full[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   old_value = cycle_full[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  old_value = instret_full[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_value = instret_full[63:32];
`endif
      default:      implemented = 1'b0;
    endcase
  end

  always_comb begin
    new_value = old_value;
    case (op)
      OP_RW:   new_value = src;
      OP_RS:   new_value = old_value | src;
      OP_RC:   new_value = old_value & ~src;
      default: new_value = old_value;
    endcase
  end

  // ------------------------------------------------------------ trap state
  // NOTE: all state here is clocked, so only non-blocking assignments are used;
  // blocking ones would let later statements see the updated value mid-edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtvec        <= {MTVEC_RESET[31:2], 2'b00};
      mscratch     <= 32'd0;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
    end else if (i_trap) begin
      mepc         <= {i_trap_pc[31:2], 2'b00};
      mcause       <= i_trap_cause;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (i_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (commit) begin
      case (csr)
        CSR_MSTATUS: begin
          mstatus_mie  <= new_value[3];
          mstatus_mpie <= new_value[7];
        end
        CSR_MTVEC:    mtvec    <= {new_value[31:2], 2'b00};
        CSR_MSCRATCH: mscratch <= new_value;
        CSR_MEPC:     mepc     <= {new_value[31:2], 2'b00};
        CSR_MCAUSE:   mcause   <= new_value;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------- counters
`ifdef TINY_RV_CSR_COUNTERS_EN
  logic [COUNTER_WIDTH-1:0] mcycle;
  logic [COUNTER_WIDTH-1:0] minstret;

  assign cycle_full   = 64'(mcycle);
  assign instret_full = 64'(minstret);

  // A CSR write replaces the whole counter for that cycle, so the increment is lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcycle <= '0;
    end else if (commit && csr == CSR_MCYCLE) begin
      mcycle <= COUNTER_WIDTH'({cycle_full[63:32], new_value});
    end else if (commit && csr == CSR_MCYCLEH) begin
      mcycle <= COUNTER_WIDTH'({new_value, cycle_full[31:0]});
    end else begin
      mcycle <= mcycle + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      minstret <= '0;
    end else if (commit && csr == CSR_MINSTRET) begin
      minstret <= COUNTER_WIDTH'({instret_full[63:32], new_value});
    end else if (commit && csr == CSR_MINSTRETH) begin
      minstret <= COUNTER_WIDTH'({new_value, instret_full[31:0]});
    end else if (i_retire) begin
      minstret <= minstret + 1'b1;
    end
  end
`else
  logic unused_counter_inputs;

  assign cycle_full            = 64'd0;
  assign instret_full          = 64'd0;
  assign unused_counter_inputs = i_retire & (COUNTER_WIDTH > 32);
`endif

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;
  assign mie_o   = mstatus_mie;

endmodule

// File: tb/tb_tiny_rv_csr_file.sv
// Directed bench for tiny_rv_csr_file; counter steps follow TINY_RV_CSR_COUNTERS_EN.
module tb_tiny_rv_csr_file;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  src_idx;
  logic [31:0] rs1;
  logic [11:0] csr;
  logic        i_retire;
  logic        i_trap;
  logic [31:0] i_trap_pc;
  logic [31:0] i_trap_cause;
  logic        i_mret;
  logic        active;
  logic        illegal;
  logic [31:0] result;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int checks = 0;
  int errors = 0;

  tiny_rv_csr_file #(
    .COUNTER_WIDTH(64),
    .MTVEC_RESET  (32'h8000_0103),
    .HART_ID      (32'h0000_0005)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .opcode      (opcode),
    .funct3      (funct3),
    .src_idx     (src_idx),
    .rs1         (rs1),
    .csr         (csr),
    .i_retire    (i_retire),
    .i_trap      (i_trap),
    .i_trap_pc   (i_trap_pc),
    .i_trap_cause(i_trap_cause),
    .i_mret      (i_mret),
    .active      (active),
    .illegal     (illegal),
    .result      (result),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o),
    .mie_o       (mie_o)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_valid      = 1'b0;
    opcode       = 7'd0;
    funct3       = 3'd0;
    src_idx      = 5'd0;
    rs1          = 32'd0;
    csr          = 12'd0;
    i_retire     = 1'b0;
    i_trap       = 1'b0;
    i_trap_pc    = 32'd0;
    i_trap_cause = 32'd0;
    i_mret       = 1'b0;
  endtask

  task automatic instr(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] idx, input logic [31:0] val);
    i_valid = 1'b1;
    opcode  = 7'b1110011;
    funct3  = f3;
    csr     = addr;
    src_idx = idx;
    rs1     = val;
    #1;
  endtask

  // Inputs change on the falling edge; the rising edge commits.
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    @(negedge i_clk);
    check("mtvec_in_reset", mtvec_o, 32'h8000_0100);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("reset_mtvec", mtvec_o, 32'h8000_0100);
    check("reset_mepc", mepc_o, 32'd0);
    check("reset_mie", 32'(mie_o), 32'd0);
    check("idle_active", 32'(active), 32'd0);
    check("idle_result", result, 32'd0);

    // CSRRS mtvec, x0: pure read
    instr(3'b010, 12'h305, 5'd0, 32'hFFFF_FFFF);
    check("mtvec_read_active", 32'(active), 32'd1);
    check("mtvec_read_illegal", 32'(illegal), 32'd0);
    check("mtvec_read_result", result, 32'h8000_0100);
    tick(); idle(); #1;
    check("mtvec_no_write", mtvec_o, 32'h8000_0100);

    // mscratch RW then RC
    instr(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF);
    check("mscratch_rw_old", result, 32'd0);
    tick();
    instr(3'b011, 12'h340, 5'd2, 32'h0000_FFFF);
    check("mscratch_rc_old", result, 32'hDEAD_BEEF);
    tick();
    instr(3'b010, 12'h340, 5'd0, 32'd0);
    check("mscratch_after_rc", result, 32'hDEAD_0000);

    // CSRRSI mstatus, 8 sets MIE; MPP reads 11
    instr(3'b110, 12'h300, 5'd8, 32'd0);
    check("mstatus_reset_read", result, 32'h0000_1800);
    tick(); idle(); #1;
    check("mie_set", 32'(mie_o), 32'd1);
    instr(3'b010, 12'h300, 5'd0, 32'd0);
    check("mstatus_mie", result, 32'h0000_1808);

    // Trap entry
    idle();
    i_trap = 1'b1; i_trap_pc = 32'h0000_1236; i_trap_cause = 32'd11;
    tick(); idle(); #1;
    check("trap_mepc", mepc_o, 32'h0000_1234);
    check("trap_mie", 32'(mie_o), 32'd0);
    instr(3'b010, 12'h342, 5'd0, 32'd0);
    check("trap_mcause", result, 32'd11);
    instr(3'b010, 12'h300, 5'd0, 32'd0);
    check("trap_mstatus", result, 32'h0000_1880);

    // MRET
    idle();
    i_mret = 1'b1;
    tick(); idle(); #1;
    check("mret_mie", 32'(mie_o), 32'd1);
    instr(3'b010, 12'h300, 5'd0, 32'd0);
    check("mret_mstatus", result, 32'h0000_1888);

    // Trap and CSRRW mepc in the same cycle: trap wins
    instr(3'b001, 12'h341, 5'd3, 32'h0000_0040);
    i_trap = 1'b1; i_trap_pc = 32'h0000_2000; i_trap_cause = 32'd2;
    #1;
    check("trapwr_old_mepc", result, 32'h0000_1234);
    tick(); idle(); #1;
    check("trapwr_mepc", mepc_o, 32'h0000_2000);
    instr(3'b010, 12'h342, 5'd0, 32'd0);
    check("trapwr_mcause", result, 32'd2);

    // Illegal accesses
    instr(3'b001, 12'hC00, 5'd1, 32'h0000_00FF);
    check("ro_write_illegal", 32'(illegal), 32'd1);
    check("ro_write_result", result, 32'd0);
    instr(3'b001, 12'h7C0, 5'd1, 32'h0000_00FF);
    check("unimpl_illegal", 32'(illegal), 32'd1);
    check("unimpl_result", result, 32'd0);
    tick();
    instr(3'b010, 12'h340, 5'd0, 32'd0);
    check("unimpl_no_change", result, 32'hDEAD_0000);
    check("unimpl_mepc_kept", mepc_o, 32'h0000_2000);

    // Low bits of mepc/mtvec read zero
    instr(3'b001, 12'h341, 5'd1, 32'h0000_1237);
    tick();
    instr(3'b001, 12'h305, 5'd1, 32'h0000_0203);
    tick(); idle(); #1;
    check("mepc_align", mepc_o, 32'h0000_1234);
    check("mtvec_align", mtvec_o, 32'h0000_0200);

    // misa write ignored, mhartid read-only
    instr(3'b001, 12'h301, 5'd1, 32'd0);
    check("misa_write_legal", 32'(illegal), 32'd0);
    check("misa_value", result, 32'h4000_0100);
    tick();
    instr(3'b010, 12'h301, 5'd0, 32'd0);
    check("misa_unchanged", result, 32'h4000_0100);
    instr(3'b010, 12'hF14, 5'd0, 32'd0);
    check("mhartid_value", result, 32'd5);
    check("mhartid_read_legal", 32'(illegal), 32'd0);
    instr(3'b001, 12'hF14, 5'd1, 32'd0);
    check("mhartid_write_illegal", 32'(illegal), 32'd1);

    // Non-CSR encodings
    instr(3'b000, 12'h300, 5'd0, 32'd0);
    check("f3_000_inactive", 32'(active), 32'd0);
    instr(3'b100, 12'h300, 5'd0, 32'd0);
    check("f3_100_inactive", 32'(active), 32'd0);
    check("f3_100_result", result, 32'd0);
    opcode = 7'b0110011; funct3 = 3'b001; #1;
    check("other_opcode_inactive", 32'(active), 32'd0);

`ifdef TINY_RV_CSR_COUNTERS_EN
    instr(3'b010, 12'hC00, 5'd0, 32'd0);
    check("cycle_read_legal", 32'(illegal), 32'd0);
    instr(3'b101, 12'hB00, 5'd5, 32'd0);
    tick();
    instr(3'b010, 12'hB00, 5'd0, 32'd0);
    check("mcycle_written", result, 32'd5);
    tick();
    check("mcycle_incr", result, 32'd6);
    instr(3'b001, 12'hB80, 5'd1, 32'd0);
    tick();
    instr(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    tick();
    instr(3'b010, 12'hB80, 5'd0, 32'd0);
    check("mcycleh_before_wrap", result, 32'd0);
    tick();
    check("mcycleh_after_wrap", result, 32'd1);
    instr(3'b010, 12'hB00, 5'd0, 32'd0);
    check("mcycle_after_wrap", result, 32'd0);
    instr(3'b001, 12'hB02, 5'd1, 32'd0);
    tick(); idle();
    i_retire = 1'b1;
    tick(); tick(); tick();
    i_retire = 1'b0;
    instr(3'b010, 12'hB02, 5'd0, 32'd0);
    check("minstret_count", result, 32'd3);
    instr(3'b010, 12'hC02, 5'd0, 32'd0);
    check("instret_shadow", result, 32'd3);
`else
    instr(3'b010, 12'hB00, 5'd0, 32'd0);
    check("mcycle_absent_illegal", 32'(illegal), 32'd1);
    check("mcycle_absent_result", result, 32'd0);
    instr(3'b010, 12'hC00, 5'd0, 32'd0);
    check("cycle_absent_illegal", 32'(illegal), 32'd1);
`endif

    // Reset arriving with a write in flight
    instr(3'b001, 12'h340, 5'd1, 32'h1234_5678);
    i_rst = 1'b1; #1;
    check("rst_comb_active", 32'(active), 32'd1);
    check("rst_comb_result", result, 32'hDEAD_0000);
    tick();
    check("rst_mtvec", mtvec_o, 32'h8000_0100);
    i_rst = 1'b0;
    instr(3'b010, 12'h340, 5'd0, 32'd0);
    check("rst_mscratch", result, 32'd0);
    check("rst_mepc", mepc_o, 32'd0);

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
